// File: rtl/fifo_drain_packer_lib_pkg.sv
// Shared state encodings and slot-decode helper for the FIFO drain packer.
package fifo_drain_packer_lib_pkg;

  localparam int MAX_PACK_NUM = 16;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } pack_state_e;

  // One-hot slot select for the beat index; the caller keeps the low PACK_NUM bits.
  function automatic logic [MAX_PACK_NUM-1:0] beat_decode(input logic [3:0] idx);
    logic [MAX_PACK_NUM-1:0] dec;
    dec = {MAX_PACK_NUM{1'b0}};
    dec[idx] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/fifo_drain_packer_lib.sv
// Drain stage behind the one-in-one-out FIFO: packs PACK_NUM popped entries into one wide,
// registered valid/ready word with a contiguous beat mask; flush emits a partial pack.
module fifo_drain_packer_lib
  import fifo_drain_packer_lib_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int PACK_NUM  = 4,
  localparam int CNT_WIDTH = $clog2(PACK_NUM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fifo_vld,
  input  logic [DATA_SIZE-1:0]          fifo_data,
  output logic                          fifo_pick_rdy,
  input  logic                          flush,
  output logic                          pack_vld,
  output logic [DATA_SIZE*PACK_NUM-1:0] pack_data,
  output logic [PACK_NUM-1:0]           pack_mask,
  input  logic                          pack_rdy
);

  pack_state_e            state_r;
  logic [CNT_WIDTH-1:0]   beat_cnt_r;
  logic [PACK_NUM-1:0]    mask_r;
  logic [DATA_SIZE-1:0]   slot_r [PACK_NUM];

  logic                   pick_rdy_s;
  logic                   xfer_s;
  logic                   pop_s;
  logic                   last_beat_s;
  logic                   flush_go_s;
  logic [CNT_WIDTH-1:0]   slot_idx_s;
  logic [MAX_PACK_NUM-1:0] dec_s;
  logic [PACK_NUM-1:0]    slot_sel_s;
  logic [PACK_NUM-1:0]    slot_en_s;

  // Handshake decode; pick_rdy depends only on state and pack_rdy so no loop through fifo_vld.
  always_comb begin
    pick_rdy_s = 1'b1;
    xfer_s     = 1'b0;
    slot_idx_s = {CNT_WIDTH{1'b0}};
    if (state_r == ST_OUT) begin
      pick_rdy_s = pack_rdy;
      xfer_s     = pack_rdy;
      slot_idx_s = {CNT_WIDTH{1'b0}};
    end else begin
      pick_rdy_s = 1'b1;
      xfer_s     = 1'b0;
      slot_idx_s = beat_cnt_r;
    end
    pop_s       = fifo_vld & pick_rdy_s;
    last_beat_s = (beat_cnt_r == CNT_WIDTH'(PACK_NUM - 1));
    flush_go_s  = flush & ((beat_cnt_r != {CNT_WIDTH{1'b0}}) | pop_s);
    dec_s       = beat_decode(4'(slot_idx_s));
    slot_sel_s  = dec_s[PACK_NUM-1:0];
    // A transfer clears every slot; a same-cycle pop then refills slot 0 only.
    slot_en_s   = ({PACK_NUM{pop_s}} & slot_sel_s) | {PACK_NUM{xfer_s}};
  end

  for (genvar k = 0; k < PACK_NUM; k++) begin : g_slot
    // Per-slot enabled data register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_r[k] <= {DATA_SIZE{1'b0}};
      end else if (slot_en_s[k]) begin
        slot_r[k] <= (pop_s & slot_sel_s[k]) ? fifo_data : {DATA_SIZE{1'b0}};
      end
    end
    assign pack_data[k*DATA_SIZE +: DATA_SIZE] = slot_r[k];
  end

  // Accumulate/present FSM with beat counter and mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_ACC;
      beat_cnt_r <= {CNT_WIDTH{1'b0}};
      mask_r     <= {PACK_NUM{1'b0}};
    end else begin
      case (state_r)
        ST_ACC: begin
          if (pop_s) begin
            mask_r[beat_cnt_r] <= 1'b1;
          end
          if ((pop_s && last_beat_s) || flush_go_s) begin
            beat_cnt_r <= {CNT_WIDTH{1'b0}};
            state_r    <= ST_OUT;
          end else if (pop_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_WIDTH'(1);
          end
        end
        ST_OUT: begin
          if (xfer_s) begin
            state_r <= ST_ACC;
            if (pop_s) begin
              mask_r     <= {{(PACK_NUM-1){1'b0}}, 1'b1};
              beat_cnt_r <= CNT_WIDTH'(1);
            end else begin
              mask_r     <= {PACK_NUM{1'b0}};
              beat_cnt_r <= {CNT_WIDTH{1'b0}};
            end
          end
        end
        default: begin
          state_r    <= ST_ACC;
          beat_cnt_r <= {CNT_WIDTH{1'b0}};
          mask_r     <= {PACK_NUM{1'b0}};
        end
      endcase
    end
  end

  assign fifo_pick_rdy = pick_rdy_s;
  assign pack_vld      = (state_r == ST_OUT);
  assign pack_mask     = mask_r;

endmodule

// File: tb/tb_fifo_drain_packer_lib.sv
// Directed bench for fifo_drain_packer_lib (DATA_SIZE=32, PACK_NUM=4) with an expected-pack scoreboard.
module tb_fifo_drain_packer_lib;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_vld;
  logic [31:0]  fifo_data;
  logic         fifo_pick_rdy;
  logic         flush;
  logic         pack_vld;
  logic [127:0] pack_data;
  logic [3:0]   pack_mask;
  logic         pack_rdy;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   mask;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  fifo_drain_packer_lib #(.DATA_SIZE(32), .PACK_NUM(4)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_vld(fifo_vld), .fifo_data(fifo_data),
    .fifo_pick_rdy(fifo_pick_rdy), .flush(flush), .pack_vld(pack_vld),
    .pack_data(pack_data), .pack_mask(pack_mask), .pack_rdy(pack_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d3, input logic [31:0] d2, input logic [31:0] d1,
                      input logic [31:0] d0, input logic [3:0] m);
    exp_t e;
    e.data = {d3, d2, d1, d0};
    e.mask = m;
    sb.push_back(e);
  endtask

  // Drive one cycle; optionally check fifo_pick_rdy before the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic fl, input logic rdy,
                      input logic chk_pr, input logic exp_pr);
    fifo_vld  = v;
    fifo_data = d;
    flush     = fl;
    pack_rdy  = rdy;
    #1;
    if (chk_pr) chk("pick_rdy", {127'd0, fifo_pick_rdy}, {127'd0, exp_pr});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted pack must match the oldest expected pack.
  always @(negedge clk) begin
    if (rst_n && pack_vld && pack_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_pack", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pack_data", pack_data, e.data);
        chk("pack_mask", {124'd0, pack_mask}, {124'd0, e.mask});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    rst_n = 1'b0; fifo_vld = 1'b0; fifo_data = 32'd0; flush = 1'b0; pack_rdy = 1'b0;
    #12;
    chk("rst_vld",  {127'd0, pack_vld}, 128'd0);
    chk("rst_mask", {124'd0, pack_mask}, 128'd0);
    chk("rst_data", pack_data, 128'd0);
    chk("rst_pick_rdy", {127'd0, fifo_pick_rdy}, 128'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: four back-to-back pops, pack valid one cycle after the last
    push(32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000, 4'b1111);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA000_0000 + i, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t1_latency_vld", {127'd0, pack_vld}, 128'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t1_vld_after_xfer", {127'd0, pack_vld}, 128'd0);

    // 2: eight continuous pops, no bubble
    push(32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000, 4'b1111);
    push(32'hE000_0007, 32'hE000_0006, 32'hE000_0005, 32'hE000_0004, 4'b1111);
    for (int i = 0; i < 8; i++) step(1'b1, 32'hE000_0000 + i, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 3: partial pack via flush, then flush of an empty accumulator
    push(32'd0, 32'd0, 32'hB000_0001, 32'hB000_0000, 4'b0011);
    step(1'b1, 32'hB000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_flush_vld", {127'd0, pack_vld}, 128'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_empty_flush_vld", {127'd0, pack_vld}, 128'd0);

    // 4: backpressure holds the pack and stalls pops
    held = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    push(32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000, 4'b1111);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hD000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'hD000_0004, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t4_hold_data", pack_data, held);
    end
    step(1'b1, 32'hD000_0004, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t4_new_mask", {124'd0, pack_mask}, 128'd1);
    chk("t4_new_vld", {127'd0, pack_vld}, 128'd0);
    push(32'hD000_0007, 32'hD000_0006, 32'hD000_0005, 32'hD000_0004, 4'b1111);
    for (int i = 5; i < 8; i++) step(1'b1, 32'hD000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: flush with 3rd pop, then flush with 4th pop
    push(32'd0, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000, 4'b0111);
    step(1'b1, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_flush3_vld", {127'd0, pack_vld}, 128'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000, 4'b1111);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hF000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hF000_0003, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_idle_vld", {127'd0, pack_vld}, 128'd0);

    // 6: async reset mid-pack and while presenting
    step(1'b1, 32'h6000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h6000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    fifo_vld = 1'b0;
    rst_n = 1'b0; #1;
    chk("t6_mid_rst_mask", {124'd0, pack_mask}, 128'd0);
    chk("t6_mid_rst_vld", {127'd0, pack_vld}, 128'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 32'h7000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_pre_rst_vld", {127'd0, pack_vld}, 128'd1);
    fifo_vld = 1'b0;
    rst_n = 1'b0; #1;
    chk("t6_out_rst_vld", {127'd0, pack_vld}, 128'd0);
    chk("t6_out_rst_mask", {124'd0, pack_mask}, 128'd0);
    chk("t6_out_rst_data", pack_data, 128'd0);
    rst_n = 1'b1;
    push(32'd0, 32'd0, 32'd0, 32'h8000_0000, 4'b0001);
    step(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_slot0_mask", {124'd0, pack_mask}, 128'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
